// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for a single 16-bit memory port: fixed priority to m1, starvation cap for m0.
// Define ARB_LOCK_EN to add the m1_lock input that lets m1 hold the bus.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned MAX_BURST   = 8
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_rw,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_rw,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
`ifdef ARB_LOCK_EN
  input  logic              m1_lock,
`endif
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam logic [3:0] WaitInit = 4'(WAIT_STATES);
  localparam logic [7:0] BurstMax = 8'(MAX_BURST);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e              state_q, state_d;
  logic [3:0]          wait_q, wait_d;
  logic [7:0]          burst_q, burst_d;
  logic                owner_q, owner_d;
  logic                busy_q, busy_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                m0_ack_q, m0_ack_d;
  logic                m1_ack_q, m1_ack_d;
  logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;

  logic lock_hold;
  logic lock_cnt;
  logic cap_hit;
  logic pick_m1;
  logic grant_any;

`ifdef ARB_LOCK_EN
  assign lock_hold = m1_lock & owner_q;
  assign lock_cnt  = m1_lock;
`else
  assign lock_hold = 1'b0;
  assign lock_cnt  = 1'b0;
`endif

  // While m1 holds the lock only m1 can win and the cap is bypassed.
  assign cap_hit   = m0_req && (burst_q == BurstMax);
  assign pick_m1   = lock_hold ? 1'b1 : (m1_req && !cap_hit);
  assign grant_any = lock_hold ? m1_req : (m0_req || m1_req);

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    burst_d     = burst_q;
    owner_d     = owner_q;
    busy_d      = busy_q;
    mem_en_d    = mem_en_q;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    m0_ack_d    = 1'b0;
    m1_ack_d    = 1'b0;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (!lock_cnt) begin
          if (!m0_req) begin
            burst_d = '0;
          end else if (grant_any && !pick_m1) begin
            burst_d = '0;
          end else if (grant_any && (burst_q != BurstMax)) begin
            burst_d = burst_q + 8'd1;
          end
        end
        if (grant_any) begin
          state_d     = StAccess;
          owner_d     = pick_m1;
          busy_d      = 1'b1;
          mem_en_d    = 1'b1;
          mem_rw_d    = pick_m1 ? m1_rw : m0_rw;
          mem_addr_d  = pick_m1 ? m1_addr : m0_addr;
          mem_wdata_d = pick_m1 ? m1_wdata : m0_wdata;
          wait_d      = WaitInit;
        end
      end
      StAccess: begin
        if (wait_q != 4'd0) begin
          wait_d = wait_q - 4'd1;
        end else begin
          if (!mem_rw_q) begin
            if (owner_q) m1_rdata_d = mem_rdata;
            else         m0_rdata_d = mem_rdata;
          end
          m0_ack_d    = !owner_q;
          m1_ack_d    = owner_q;
          mem_en_d    = 1'b0;
          mem_rw_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          state_d     = StResp;
        end
      end
      StResp: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      wait_q      <= '0;
      burst_q     <= '0;
      owner_q     <= 1'b0;
      busy_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      burst_q     <= burst_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      mem_en_q    <= mem_en_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      m0_ack_q    <= m0_ack_d;
      m1_ack_q    <= m1_ack_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_rw    = mem_rw_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: random masters, transaction-level arbitration model,
// memory whose read data is only valid in the last wait-state cycle.
module tb_mem_bus_arbiter;

  localparam int WS = 1;
  localparam int MB = 2;

  logic        clk_in = 1'b0;
  logic        rst    = 1'b0;
  logic        req_v   [2];
  logic        rw_v    [2];
  logic [15:0] addr_v  [2];
  logic [15:0] wdata_v [2];
  logic        m0_ack, m1_ack, mem_en, mem_rw, busy, owner;
  logic [15:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef ARB_LOCK_EN
  logic        lk = 1'b0;
`endif

  always #5 clk_in = ~clk_in;

  mem_bus_arbiter #(
    .ADDR_W(16), .DATA_W(16), .WAIT_STATES(WS), .MAX_BURST(MB)
  ) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .m0_req   (req_v[0]),
    .m0_rw    (rw_v[0]),
    .m0_addr  (addr_v[0]),
    .m0_wdata (wdata_v[0]),
    .m0_ack   (m0_ack),
    .m0_rdata (m0_rdata),
    .m1_req   (req_v[1]),
    .m1_rw    (rw_v[1]),
    .m1_addr  (addr_v[1]),
    .m1_wdata (wdata_v[1]),
    .m1_ack   (m1_ack),
    .m1_rdata (m1_rdata),
`ifdef ARB_LOCK_EN
    .m1_lock  (lk),
`endif
    .mem_en   (mem_en),
    .mem_rw   (mem_rw),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .owner    (owner)
  );

  // Memory: data is only valid once WS cycles of the access have elapsed.
  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  int en_cnt = 0;
  always @(posedge clk_in) en_cnt <= mem_en ? en_cnt + 1 : 0;
  assign mem_rdata = (en_cnt == WS) ? mem_fn(mem_addr) : 16'hDEAD;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int          m;
    logic [15:0] rdata;
    int          due;
  } txn_t;

  txn_t        sb[$];
  int          cyc       = 0;
  int          mdl_left  = 0;
  int          passed    = 0;
  bit          mdl_owner = 1'b0;
  logic [15:0] last_rd [2];
  bit          lock_run  = 1'b0;

  // Monitor + reference model: one step per clock edge, sampled 1 time unit after it.
  always @(posedge clk_in) begin
    #1;
    if (rst) begin
      sb.delete();
      mdl_left  = 0;
      passed    = 0;
      mdl_owner = 1'b0;
      last_rd[0] = '0;
      last_rd[1] = '0;
    end else begin
      bit   lk_s, lock_act, grant, exp_m;
      txn_t it;
      cyc++;
`ifdef ARB_LOCK_EN
      lk_s = lk;
`else
      lk_s = 1'b0;
`endif
      if (sb.size() != 0 && sb[0].due == cyc) begin
        it = sb.pop_front();
        chk("ack_m0", m0_ack, it.m == 0);
        chk("ack_m1", m1_ack, it.m == 1);
        chk("rdata", (it.m == 0) ? m0_rdata : m1_rdata, it.rdata);
        chk("mem_addr_resp", mem_addr, 16'h0);
      end else begin
        chk("no_ack", {m0_ack, m1_ack}, 2'b00);
      end
      if (mdl_left != 0) begin
        chk("mem_en_phase", mem_en, mdl_left > 2);
        chk("busy_phase", busy, mdl_left > 1);
        mdl_left--;
      end else begin
        lock_act = lk_s && mdl_owner;
        if (lock_act) begin
          grant = req_v[1];
          exp_m = 1'b1;
        end else begin
          grant = req_v[0] || req_v[1];
          exp_m = req_v[1] && !(req_v[0] && passed == MB);
        end
        if (!lk_s) begin
          if (!req_v[0])        passed = 0;
          else if (!grant)      passed = passed;
          else if (exp_m)       passed = (passed < MB) ? passed + 1 : passed;
          else                  passed = 0;
        end
        if (grant) begin
          chk("grant_en", mem_en, 1'b1);
          chk("grant_owner", owner, exp_m);
          chk("grant_rw", mem_rw, rw_v[exp_m]);
          chk("grant_addr", mem_addr, addr_v[exp_m]);
          chk("grant_wdata", mem_wdata, wdata_v[exp_m]);
          it.m     = exp_m;
          it.due   = cyc + 1 + WS;
          it.rdata = rw_v[exp_m] ? last_rd[exp_m] : mem_fn(addr_v[exp_m]);
          last_rd[exp_m] = it.rdata;
          sb.push_back(it);
          mdl_owner = exp_m;
          mdl_left  = 2 + WS;
        end else begin
          chk("idle_en", mem_en, 1'b0);
          chk("idle_busy", busy, 1'b0);
        end
      end
    end
  end

`ifdef ARB_LOCK_EN
  initial begin
    forever begin
      @(negedge clk_in);
      if (!lock_run) lk = 1'b0;
      else if ($urandom_range(0, 7) == 0) lk = ~lk;
    end
  end
`endif

  task automatic drive_master(input int k, input int ntx, input int gap_pct);
    bit got;
    for (int t = 0; t < ntx; t++) begin
      if ($urandom_range(0, 99) < gap_pct) repeat ($urandom_range(1, 5)) @(negedge clk_in);
      req_v[k]   = 1'b1;
      rw_v[k]    = 1'($urandom_range(0, 1));
      addr_v[k]  = 16'($urandom);
      wdata_v[k] = 16'($urandom);
      got = 1'b0;
      for (int c = 0; c < 300 && !got; c++) begin
        @(posedge clk_in);
        #1;
        got = (k == 0) ? m0_ack : m1_ack;
      end
      chk($sformatf("ack_wait_m%0d", k), got, 1'b1);
      @(negedge clk_in);
      req_v[k] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    for (int k = 0; k < 2; k++) begin
      req_v[k] = 1'b0; rw_v[k] = 1'b0; addr_v[k] = '0; wdata_v[k] = '0;
    end
    #1 rst = 1'b1;
    #1;
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_owner", owner, 1'b0);
    chk("rst_acks", {m0_ack, m1_ack}, 2'b00);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 32'h0);
    repeat (2) @(negedge clk_in);
    rst = 1'b0;

    // Continuous contention exercises priority and the starvation cap.
    @(negedge clk_in);
    fork
      drive_master(0, 12, 0);
      drive_master(1, 12, 0);
    join

    // Random traffic with gaps (and random lock when present).
    lock_run = 1'b1;
    fork
      drive_master(0, 40, 40);
      drive_master(1, 40, 40);
    join
    lock_run = 1'b0;
    repeat (8) @(negedge clk_in);

    // Reset in the middle of an access.
    req_v[0] = 1'b1; rw_v[0] = 1'b0; addr_v[0] = 16'h0010; wdata_v[0] = 16'h0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk_in);
      #1;
      seen = mem_en;
    end
    chk("rst_test_grant", seen, 1'b1);
    #1 rst = 1'b1;
    req_v[0] = 1'b0;
    #1;
    chk("midrst_mem_en", mem_en, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_acks", {m0_ack, m1_ack}, 2'b00);
    chk("midrst_rdata", {m0_rdata, m1_rdata}, 32'h0);
    repeat (2) @(negedge clk_in);
    rst = 1'b0;
    @(negedge clk_in);
    fork
      drive_master(0, 6, 30);
      drive_master(1, 6, 30);
    join

    repeat (12) @(posedge clk_in);
    #1;
    chk("sb_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
